// File: rtl/aimc_lib_pkg.sv
// Shared types for the in-order reorder scheduler (orde_sched).
// Index and count typedefs here are sized for the default 32-entry configuration.
package aimc_lib;

    localparam int unsigned ORDE_DEFAULT_DEPTH = 32;
    localparam int unsigned ORDE_IDX_W         = $clog2(ORDE_DEFAULT_DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } orde_state_e;

    typedef logic [ORDE_IDX_W-1:0] orde_idx_t;
    typedef logic [ORDE_IDX_W:0]   orde_cnt_t;

endpackage

// File: rtl/orde_sched_age_sel.sv
// Oldest-first hit selector: first set bit of the hit vector scanning upward
// from the head index with wraparound. Purely combinational.
module orde_age_sel #(
    parameter int unsigned DEPTH = 32
) (
    input  logic [DEPTH-1:0]         hit_vec,
    input  logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH)-1:0] sel_idx,
    output logic                     found
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Index arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        logic [IDX_W-1:0] probe;
        sel_idx = '0;
        found   = 1'b0;
        probe   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            probe = head + IDX_W'(i);
            if (!found && hit_vec[probe]) begin
                found   = 1'b1;
                sel_idx = probe;
            end
        end
    end

endmodule

// File: rtl/orde_sched.sv
// In-order reorder scheduler: allocates CAM entries for requests, completes them
// out of order on responses, retires them in order. Optional watchdog: ORDE_TIMEOUT_EN.
module orde_sched
    import aimc_lib::*;
#(
    parameter int unsigned CAM_DEPTH      = 32,
    parameter int unsigned CAM_WIDTH      = 23,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [CAM_WIDTH-1:0]         req_key,
    input  logic                         rsp_valid,
    input  logic [CAM_WIDTH-1:0]         rsp_key,
    input  logic                         flush,
    output logic [CAM_WIDTH-1:0]         cam_in,
    output logic                         cam_in_valid,
    output logic [$clog2(CAM_DEPTH)-1:0] cam_in_idx,
    output logic [CAM_WIDTH-1:0]         cam_key,
    output logic                         cam_key_valid,
    input  logic [CAM_DEPTH-1:0]         match_entry_array,
    output logic [$clog2(CAM_DEPTH)-1:0] match_idx,
    output logic                         match_idx_valid,
    output logic [$clog2(CAM_DEPTH)-1:0] status_mem_idx,
    output logic                         status_mem_idx_valid,
    input  logic                         status,
    output logic [$clog2(CAM_DEPTH)-1:0] pop_idx,
    output logic                         pop_idx_valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(CAM_DEPTH)-1:0] out_idx,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int unsigned IDX_W = $clog2(CAM_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    if (CAM_DEPTH < 4 || (CAM_DEPTH & (CAM_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("orde_sched: CAM_DEPTH must be a power of two >= 4 and TIMEOUT_CYCLES >= 1");
    end

    orde_state_e state_q, state_d;
    idx_t        head_q, head_d;
    idx_t        tail_q, tail_d;
    cnt_t        count_q, count_d;
    logic        rsp_err_q, rsp_err_d;

    logic        alloc;
    logic        retire;
    logic        hit_found;
    idx_t        hit_idx;

    orde_age_sel #(
        .DEPTH (CAM_DEPTH)
    ) u_age_sel (
        .hit_vec (match_entry_array),
        .head    (head_q),
        .sel_idx (hit_idx),
        .found   (hit_found)
    );

    // rst_n gates the input-driven handshakes so nothing leaks out during reset.
    always_comb begin
        req_ready            = rst_n && (state_q == RUN) && (count_q < cnt_t'(CAM_DEPTH));
        alloc                = req_valid && req_ready;
        cam_in               = req_key;
        cam_in_valid         = alloc;
        cam_in_idx           = tail_q;
        cam_key              = rsp_key;
        cam_key_valid        = rsp_valid && rst_n;
        match_idx            = hit_idx;
        match_idx_valid      = cam_key_valid && hit_found;
        status_mem_idx       = head_q;
        status_mem_idx_valid = (count_q != '0);
        out_valid            = status && status_mem_idx_valid;
        out_idx              = head_q;
        retire               = out_valid && out_ready;
        pop_idx              = head_q;
        pop_idx_valid        = retire;
        busy                 = (count_q != '0) || (state_q == DRAIN);
        rsp_err              = rsp_err_q;
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;
        rsp_err_d = cam_key_valid && !hit_found;
        if (alloc) tail_d = tail_q + idx_t'(1);
        if (retire) head_d = head_q + idx_t'(1);
        case ({alloc, retire})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (count_q == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rsp_err_q <= rsp_err_d;
        end
    end

`ifdef ORDE_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [AGE_W-1:0] age_q, age_d;
    logic             timeout_err_q, timeout_err_d;

    // Age tracks how long the current head has waited; it saturates at the limit.
    always_comb begin
        age_d = age_q;
        if (retire || count_q == '0) begin
            age_d = '0;
        end else if (age_q < AGE_W'(TIMEOUT_CYCLES)) begin
            age_d = age_q + AGE_W'(1);
        end
        timeout_err_d = timeout_err_q || (age_d == AGE_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            age_q         <= age_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
